// File: rtl/lcm_pkg.sv
// Shared types for the lcm/gcd operand-recovery path: job status codes, FSM states, product width.
package lcm_pkg;

  typedef enum logic [1:0] {
    ERR_OK,
    ERR_ZERO,
    ERR_INEXACT,
    ERR_OVF
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  // L*G needs 2*dw + dw bits
  function automatic int pw(input int dw);
    return 3 * dw;
  endfunction

endpackage

// File: rtl/udiv_step.sv
// One restoring-division step, purely combinational: shift in a dividend bit, subtract divisor if it fits.
// The incoming remainder is always below the divisor, so DW bits of it are enough to form the shifted value.
module udiv_step #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] rem,
  input  logic          din,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   rem_next,
  output logic          q_bit
);

  logic [DW:0] shifted;
  logic [DW:0] dvs;

  always_comb begin
    shifted  = {rem, din};
    dvs      = {1'b0, divisor};
    q_bit    = (shifted >= dvs);
    rem_next = q_bit ? (shifted - dvs) : shifted;
  end

endmodule

// File: rtl/lcm_recover.sv
// Recovers B = (L*G)/A: 1 cycle for zero jobs, PW+2 cycles otherwise; one job in flight.
// in_ready only in idle; result and status hold steady while out_valid && !out_ready.
module lcm_recover
  import lcm_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*DW-1:0] lcm_i,
  input  logic [DW-1:0] gcd_i,
  input  logic [DW-1:0] data_a_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_b_o,
  output err_e          err_o
);

  localparam int PW = pw(DW);
  localparam int CW = $clog2(PW);

  state_e          state_q, state_d;
  logic [2*DW-1:0] l_q;
  logic [DW-1:0]   g_q;
  logic [DW-1:0]   a_q;
  logic            zero_q;
  logic [PW-1:0]   p_q;
  logic [DW:0]     rem_q;
  logic [PW-1:0]   q_q;
  logic [CW-1:0]   cnt_q;

  logic [PW-1:0]   prod;
  logic [DW:0]     rem_next;
  logic            q_bit;

  assign prod = {{DW{1'b0}}, l_q} * {{(2*DW){1'b0}}, g_q};

  udiv_step #(.DW(DW)) u_step (
    .rem      (rem_q[DW-1:0]),
    .din      (p_q[cnt_q]),
    .divisor  (a_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // zero operands skip the divider entirely
          state_d = ((data_a_i == '0) || (gcd_i == '0)) ? S_DONE : S_MUL;
        end
      end
      S_MUL:  state_d = S_DIV;
      S_DIV:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q    <= '0;
      g_q    <= '0;
      a_q    <= '0;
      zero_q <= 1'b0;
      p_q    <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            l_q    <= lcm_i;
            g_q    <= gcd_i;
            a_q    <= data_a_i;
            zero_q <= (data_a_i == '0) || (gcd_i == '0);
          end
        end
        S_MUL: begin
          p_q   <= prod;
          rem_q <= '0;
          q_q   <= '0;
          cnt_q <= CW'(PW - 1);
        end
        S_DIV: begin
          rem_q        <= rem_next;
          q_q[cnt_q]   <= q_bit;
          cnt_q        <= cnt_q - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  // status priority: zero operand, remainder, quotient overflow
  always_comb begin
    data_b_o = '0;
    err_o    = ERR_OK;
    if (state_q == S_DONE) begin
      if (zero_q)                   err_o = ERR_ZERO;
      else if (rem_q != '0)         err_o = ERR_INEXACT;
      else if (q_q[PW-1:DW] != '0)  err_o = ERR_OVF;
      else                          data_b_o = q_q[DW-1:0];
    end
  end

endmodule

// File: tb/tb_lcm_recover.sv
// Directed bench for lcm_recover (DW=8): results, status codes, latency, backpressure and mid-job reset.
module tb_lcm_recover;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] lcm_i;
  logic [7:0]  gcd_i;
  logic [7:0]  data_a_i;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  data_b_o;
  lcm_pkg::err_e err_o;

  int checks;
  int failures;

  localparam logic [1:0] E_OK      = 2'd0;
  localparam logic [1:0] E_ZERO    = 2'd1;
  localparam logic [1:0] E_INEXACT = 2'd2;
  localparam logic [1:0] E_OVF     = 2'd3;

  lcm_recover #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lcm_i     (lcm_i),
    .gcd_i     (gcd_i),
    .data_a_i  (data_a_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_b_o  (data_b_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer a job at #1 after an edge, measure edges until out_valid (accept edge counts as 1),
  // check result, then let the handshake complete with out_ready=1.
  task automatic run_job(input string tag, input logic [15:0] l, input logic [7:0] g,
                         input logic [7:0] a, input logic [7:0] eb, input logic [1:0] ee,
                         input int elat);
    int lat;
    lcm_i    = l;
    gcd_i    = g;
    data_a_i = a;
    in_valid = 1'b1;
    out_ready = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lcm_i    = 16'hFFFF;
    gcd_i    = 8'hFF;
    data_a_i = 8'h00;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_b"}, data_b_o, eb);
    check({tag, "_err"}, err_o, ee);
    @(posedge clk); #1;
    check({tag, "_post_out_valid"}, out_valid, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int seen;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    lcm_i     = '0;
    gcd_i     = '0;
    data_a_i  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_b", data_b_o, 0);
    check("reset_err", err_o, E_OK);
    rst = 1'b0;
    @(posedge clk); #1;

    // 864/36 = 24
    run_job("exact", 16'd72, 8'd12, 8'd36, 8'd24, E_OK, 26);
    run_job("a_zero", 16'd72, 8'd12, 8'd0, 8'd0, E_ZERO, 1);
    run_job("g_zero", 16'd72, 8'd0, 8'd5, 8'd0, E_ZERO, 1);
    // 1200/36 = 33 r 12
    run_job("inexact", 16'd100, 8'd12, 8'd36, 8'd0, E_INEXACT, 26);
    // 65535*255 = 16711425
    run_job("ovf", 16'd65535, 8'd255, 8'd1, 8'd0, E_OVF, 26);
    // 65025/255 = 255
    run_job("max_ok", 16'd255, 8'd255, 8'd255, 8'd255, E_OK, 26);
    // 240/12 = 20
    run_job("small", 16'd60, 8'd4, 8'd12, 8'd20, E_OK, 26);

    // backpressure on the first job
    out_ready = 1'b0;
    lcm_i = 16'd72; gcd_i = 8'd12; data_a_i = 8'd36; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 26);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      lcm_i    = 16'(i * 37 + 5);
      gcd_i    = 8'(i + 3);
      data_a_i = 8'(i + 1);
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_b", data_b_o, 24);
      check("bp_hold_err", err_o, E_OK);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // reset while dividing
    lcm_i = 16'd72; gcd_i = 8'd12; data_a_i = 8'd36; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_mid_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_b", data_b_o, 0);
    check("abort_err", err_o, E_OK);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_output", seen, 0);
    run_job("after_abort", 16'd60, 8'd4, 8'd12, 8'd20, E_OK, 26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
